// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) round-robin arbiter onto one shared memory bus
// Each port holds one buffered request; one bus transaction is outstanding at a time.
module mem_arbiter #(
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        f_request_enable,
    input  logic        f_mode,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    input  logic [3:0]  f_wstrb,
    output logic        f_response_enable,
    output logic [31:0] f_data,

    input  logic        d_request_enable,
    input  logic        d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_response_enable,
    output logic [31:0] d_data,

    output logic        m_request_enable,
    output logic        m_mode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_response_enable,
    input  logic [31:0] m_data
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, next_state;

    logic        f_pend, d_pend;
    logic        f_mode_q, d_mode_q;
    logic [31:0] f_addr_q, d_addr_q;
    logic [31:0] f_wdata_q, d_wdata_q;
    logic [3:0]  f_wstrb_q, d_wstrb_q;

    // owner_d doubles as round-robin history: it names the last port granted.
    logic owner_d;
    logic granted_any;
    logic grant_d;
    logic resp_fire;

    assign resp_fire = (state == BUSY) && m_response_enable;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        m_request_enable = 1'b0;
        grant_d          = owner_d;
        case (state)
            IDLE: begin
                if (f_pend || d_pend) begin
                    m_request_enable = 1'b1;
                    next_state       = BUSY;
                    if (f_pend && d_pend) begin
                        grant_d = granted_any ? ~owner_d : (DATA_FIRST != 0);
                    end else begin
                        grant_d = d_pend;
                    end
                end
            end
            BUSY: begin
                if (m_response_enable) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Buffers are frozen while pending, so the bus fields stay stable for the whole transaction.
    assign m_mode  = grant_d ? d_mode_q  : f_mode_q;
    assign m_addr  = grant_d ? d_addr_q  : f_addr_q;
    assign m_wdata = grant_d ? d_wdata_q : f_wdata_q;
    assign m_wstrb = grant_d ? d_wstrb_q : f_wstrb_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_d     <= 1'b0;
            granted_any <= 1'b0;
        end else if (m_request_enable) begin
            owner_d     <= grant_d;
            granted_any <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_pend    <= 1'b0;
            f_mode_q  <= 1'b0;
            f_addr_q  <= 32'h0;
            f_wdata_q <= 32'h0;
            f_wstrb_q <= 4'h0;
        end else if (f_request_enable && !f_pend) begin
            f_pend    <= 1'b1;
            f_mode_q  <= f_mode;
            f_addr_q  <= f_addr;
            f_wdata_q <= f_wdata;
            f_wstrb_q <= f_wstrb;
        end else if (resp_fire && !owner_d) begin
            f_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_pend    <= 1'b0;
            d_mode_q  <= 1'b0;
            d_addr_q  <= 32'h0;
            d_wdata_q <= 32'h0;
            d_wstrb_q <= 4'h0;
        end else if (d_request_enable && !d_pend) begin
            d_pend    <= 1'b1;
            d_mode_q  <= d_mode;
            d_addr_q  <= d_addr;
            d_wdata_q <= d_wdata;
            d_wstrb_q <= d_wstrb;
        end else if (resp_fire && owner_d) begin
            d_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_response_enable <= 1'b0;
            d_response_enable <= 1'b0;
            f_data            <= 32'h0;
            d_data            <= 32'h0;
        end else begin
            f_response_enable <= resp_fire && !owner_d;
            d_response_enable <= resp_fire && owner_d;
            if (resp_fire && !owner_d) begin
                f_data <= m_data;
            end
            if (resp_fire && owner_d) begin
                d_data <= m_data;
            end
        end
    end

endmodule
